trap_sequencer: RTL
===================

// Module: trap_sequencer
// PURPOSE
//  Sequences trap entry and MRET for the core's single CSR write port, downstream of writeback and trap_handler.
//  On a trap it writes mepc, mcause, mtval and mstatus one per cycle, then redirects fetch to mtvec and flushes.
//  On MRET it restores mstatus and privilege, then redirects fetch to mepc.
//  Outside these sequences it arbitrates the port: normal writeback CSR writes pass straight through.
// PARAMETERS
//  XLEN          64      datapath / CSR width
//  ADDR_MSTATUS  12'h300 mstatus CSR address
//  ADDR_MEPC     12'h341 mepc CSR address
//  ADDR_MCAUSE   12'h342 mcause CSR address
//  ADDR_MTVAL    12'h343 mtval CSR address
//  VECTORED_EN   1       1: honour mtvec MODE=01 for interrupts; 0: always direct
// PORTS
//  CLK            in   1     clock, all state on posedge
//  RESET          in   1     synchronous, active-high
//  TRAP_REQ       in   1     trap_handler CS: take trap on the instruction now in WB
//  TRAP_CAUSE     in   XLEN  mcause value; bit XLEN-1 = interrupt
//  TRAP_PC        in   XLEN  PC of trapping instruction
//  TRAP_TVAL      in   XLEN  mtval value (faulting addr/instr, else 0)
//  MRET_REQ       in   1     valid MRET in WB
//  WB_ST_CSR      in   1     writeback CSR write request
//  WB_CSR_ADDR    in   12    writeback CSR address
//  WB_CSR_DATA    in   XLEN  writeback CSR data
//  MTVEC, MEPC, MSTATUS in XLEN  current CSR values (read port)
//  CSR_WE         out  1     CSR file write enable
//  CSR_WADDR      out  12    CSR write address
//  CSR_WDATA      out  XLEN  CSR write data
//  STALL          out  1     hold fetch..WB; high whenever state != IDLE
//  FLUSH          out  1     kill all younger in-flight instructions
//  PC_REDIRECT_V  out  1     load PC_REDIRECT into PC
//  PC_REDIRECT    out  XLEN  redirect target
//  PRIV_OUT       out  1     current privilege: 1=M, 0=U
// BEHAVIOUR
//  Reset: state=IDLE, PRIV_OUT=1, latches=0, so all strobes=0 and CSR_WADDR/WDATA=0.
//  RESET mid-sequence: abandon it; no further writes or redirect.
//  States: IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_REDIR, M_STATUS, M_REDIR.
//  Outputs are Moore from state + latches, except the IDLE pass-through.
//  Acceptance (IDLE only), priority: TRAP_REQ > MRET_REQ > WB_ST_CSR.
//  Trap path (trap accepted at edge k):
//   - At edge k latch TRAP_PC, TRAP_CAUSE, TRAP_TVAL, MSTATUS and MTVEC; go to T_EPC.
//   - Cycles k+1..k+4: T_EPC, T_CAUSE, T_TVAL, T_STATUS, each CSR_WE=1.
//   - mepc data = {pc[XLEN-1:2],2'b00}.
//   - New mstatus = old with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]={2{PRIV_OUT}}.
//   - PRIV_OUT<=1 on exit from T_STATUS.
//   - Cycle k+5 (T_REDIR): PC_REDIRECT_V=1, FLUSH=1; then IDLE.
//  Trap target:
//   - base = {mtvec[XLEN-1:2],2'b00}.
//   - If VECTORED_EN & mtvec[1:0]==2'b01 & cause[XLEN-1]: target = base + (cause[5:0]<<2), wrap mod 2^XLEN.
//   - Otherwise target = base.
//  MRET path (accepted at edge k):
//   - At edge k latch MSTATUS and MEPC.
//   - Cycle k+1 (M_STATUS): write mstatus with MIE=MPIE, MPIE=1, MPP=2'b00.
//   - PRIV_OUT<= (MPP!=0) on exit from M_STATUS.
//   - Cycle k+2 (M_REDIR): redirect to latched mepc, FLUSH=1; then IDLE.
//  Pass-through (IDLE, no TRAP_REQ/MRET_REQ):
//   - CSR_WE=WB_ST_CSR, addr/data = WB_* combinationally, same cycle.
//  Simultaneous events:
//   - WB_ST_CSR with TRAP_REQ: WB write is dropped (trapping instr never commits).
//   - WB_ST_CSR with MRET_REQ: WB write is dropped.
//   - TRAP_REQ with MRET_REQ: trap wins.
//   - Requests while state != IDLE are ignored; STALL keeps sources frozen.
//  TRAP_REQ held high after T_REDIR starts a new trap (upstream drops it on FLUSH).
// TESTING
//  1. Reset, then WB_ST_CSR=1 addr 0x305 data 0x80 -> CSR_WE=1 same cycle, 0x305/0x80, STALL=0.
//  2. TRAP_REQ, cause=2, PC=0x1006, tval=0xDEAD, MSTATUS=0x8, MTVEC=0x1000, PRIV=0
//     -> writes 0x341=0x1004, 0x342=2, 0x343=0xDEAD, 0x300=0x80 on k+1..k+4.
//     -> redirect 0x1000 with FLUSH at k+5; PRIV_OUT=1.
//  3. MTVEC=0x2001, cause=0x8000_0000_0000_0007 -> redirect 0x201C.
//     Same cause with VECTORED_EN=0 -> 0x2000.
//  4. MRET, MSTATUS=0x80, MEPC=0x4000 -> k+1 writes 0x300=0x88, PRIV_OUT=0.
//     -> k+2 redirect 0x4000 with FLUSH.
//  5. TRAP_REQ+MRET_REQ+WB_ST_CSR in one cycle -> only trap sequence occurs; WB write never appears.
//  6. RESET asserted in T_CAUSE -> next cycle IDLE, CSR_WE=0, no redirect, PRIV_OUT=1.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: drives the single CSR write port through trap entry and MRET.
// When idle, writeback CSR writes pass straight through to the port.
module trap_sequencer #(
  parameter int          XLEN         = 64,
  parameter logic [11:0] ADDR_MSTATUS = 12'h300,
  parameter logic [11:0] ADDR_MEPC    = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h342,
  parameter logic [11:0] ADDR_MTVAL   = 12'h343,
  parameter bit          VECTORED_EN  = 1'b1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            TRAP_REQ,
  input  logic [XLEN-1:0] TRAP_CAUSE,
  input  logic [XLEN-1:0] TRAP_PC,
  input  logic [XLEN-1:0] TRAP_TVAL,
  input  logic            MRET_REQ,
  input  logic            WB_ST_CSR,
  input  logic [11:0]     WB_CSR_ADDR,
  input  logic [XLEN-1:0] WB_CSR_DATA,
  input  logic [XLEN-1:0] MTVEC,
  input  logic [XLEN-1:0] MEPC,
  input  logic [XLEN-1:0] MSTATUS,
  output logic            CSR_WE,
  output logic [11:0]     CSR_WADDR,
  output logic [XLEN-1:0] CSR_WDATA,
  output logic            STALL,
  output logic            FLUSH,
  output logic            PC_REDIRECT_V,
  output logic [XLEN-1:0] PC_REDIRECT,
  output logic            PRIV_OUT
);
  typedef enum logic [2:0] {IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_REDIR, M_STATUS, M_REDIR} state_e;
  state_e          state_q;
  logic            priv_q;
  logic [XLEN-1:0] pc_q, cause_q, tval_q, status_q, tgt_q;
  logic [XLEN-1:0] trap_tgt, trap_sts, mret_sts;
  logic            pass, redir;
  // Redirect target is resolved at acceptance so trap and MRET share one latch.
  assign trap_tgt = {MTVEC[XLEN-1:2], 2'b00} +
                    ((VECTORED_EN && MTVEC[1:0] == 2'b01 && TRAP_CAUSE[XLEN-1]) ?
                     {{(XLEN-8){1'b0}}, TRAP_CAUSE[5:0], 2'b00} : '0);
  assign PRIV_OUT = priv_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      priv_q   <= 1'b1;
      pc_q     <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      status_q <= '0;
      tgt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (TRAP_REQ) begin
            pc_q     <= TRAP_PC;
            cause_q  <= TRAP_CAUSE;
            tval_q   <= TRAP_TVAL;
            status_q <= MSTATUS;
            tgt_q    <= trap_tgt;
            state_q  <= T_EPC;
          end else if (MRET_REQ) begin
            status_q <= MSTATUS;
            tgt_q    <= MEPC;
            state_q  <= M_STATUS;
          end
        end
        T_EPC:   state_q <= T_CAUSE;
        T_CAUSE: state_q <= T_TVAL;
        T_TVAL:  state_q <= T_STATUS;
        T_STATUS: begin
          priv_q  <= 1'b1;
          state_q <= T_REDIR;
        end
        M_STATUS: begin
          priv_q  <= |status_q[12:11];
          state_q <= M_REDIR;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_comb begin
    trap_sts        = status_q;
    trap_sts[7]     = status_q[3];
    trap_sts[3]     = 1'b0;
    trap_sts[12:11] = {2{priv_q}};
    mret_sts        = status_q;
    mret_sts[3]     = status_q[7];
    mret_sts[7]     = 1'b1;
    mret_sts[12:11] = 2'b00;
    pass  = state_q == IDLE && WB_ST_CSR && !TRAP_REQ && !MRET_REQ;
    redir = state_q == T_REDIR || state_q == M_REDIR;
    CSR_WE = pass || state_q inside {T_EPC, T_CAUSE, T_TVAL, T_STATUS, M_STATUS};
    CSR_WADDR = pass                  ? WB_CSR_ADDR  :
                state_q == T_EPC      ? ADDR_MEPC    :
                state_q == T_CAUSE    ? ADDR_MCAUSE  :
                state_q == T_TVAL     ? ADDR_MTVAL   :
                (state_q == T_STATUS || state_q == M_STATUS) ? ADDR_MSTATUS : 12'h0;
    CSR_WDATA = pass                  ? WB_CSR_DATA  :
                state_q == T_EPC      ? {pc_q[XLEN-1:2], 2'b00} :
                state_q == T_CAUSE    ? cause_q      :
                state_q == T_TVAL     ? tval_q       :
                state_q == T_STATUS   ? trap_sts     :
                state_q == M_STATUS   ? mret_sts     : '0;
    STALL         = state_q != IDLE;
    FLUSH         = redir;
    PC_REDIRECT_V = redir;
    PC_REDIRECT   = redir ? tgt_q : '0;
  end
endmodule
